// File: rtl/light_sensor_sequencer.sv
// light_sensor_sequencer
// Drives a byte-level I2C engine to run a BH1750-class ambient light sensor:
// power-on, continuous high-res mode set, conversion wait, then a repeating
// two-byte readout. Each result is published to reg1 (high byte) and reg2
// (low byte) on the same clock edge.
//
// Optional build macro: LIGHT_AVG_EN
//   Defined:   raw samples are summed into an 18-bit accumulator. Every 4th
//              sample publishes sum>>2, then the sum restarts. A NACK clears
//              the sum and the phase.
//   Undefined: every raw sample is published directly.
//
// Ports
//   FPGA_CLK1_50  in   system clock (50 MHz)
//   reset         in   synchronous, active-high
//   enable        in   run the sequencer; 0 parks in IDLE at the next bus boundary
//   cmd_valid     out  command to the I2C engine is valid
//   cmd_ready     in   engine accepts the command
//   cmd[1:0]      out  0=START 1=WRITE 2=READ 3=STOP
//   cmd_nack      out  with READ: master NACKs this (last) byte
//   wr_byte[7:0]  out  byte for WRITE
//   done          in   one-cycle pulse, the accepted command finished
//   rd_byte[7:0]  in   read data, valid with done after READ
//   ack_err       in   valid with done after WRITE, slave NACKed
//   reg1[7:0]     out  published result, high byte
//   reg2[7:0]     out  published result, low byte
//   sample_cnt    out  number of samples read, wraps 255->0
//   busy          out  sequencer is not in IDLE
//   err           out  sticky NACK flag, cleared by reset or enable 0->1
//
// State       | meaning
// ------------+--------------------------------------------------------
// ST_IDLE     | parked, waiting for enable
// ST_PWR      | START, WRITE addr+W, WRITE PWR_CMD, STOP
// ST_MODE     | START, WRITE addr+W, WRITE MODE_CMD, STOP
// ST_WAIT     | conversion wait, CONV_CYCLES cycles
// ST_READ     | START, WRITE addr+R, READ ack, READ nack, STOP
// ST_PUB      | one cycle: publish result, bump sample_cnt
// ST_ABORT    | STOP issued after a NACKed WRITE
// ST_BACKOFF  | retry wait, BACKOFF_CYCLES cycles, then back to ST_PWR

module light_sensor_sequencer #(
    parameter logic [6:0]  DEV_ADDR       = 7'h23,
    parameter logic [7:0]  PWR_CMD        = 8'h01,
    parameter logic [7:0]  MODE_CMD       = 8'h10,
    parameter int unsigned CONV_CYCLES    = 9000000,
    parameter int unsigned BACKOFF_CYCLES = 2500000,
    parameter int unsigned CNT_W          = 24
) (
    input  logic       FPGA_CLK1_50,
    input  logic       reset,
    input  logic       enable,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd,
    output logic       cmd_nack,
    output logic [7:0] wr_byte,
    input  logic       done,
    input  logic [7:0] rd_byte,
    input  logic       ack_err,
    output logic [7:0] reg1,
    output logic [7:0] reg2,
    output logic [7:0] sample_cnt,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PWR,
        ST_MODE,
        ST_WAIT,
        ST_READ,
        ST_PUB,
        ST_ABORT,
        ST_BACKOFF
    } state_t;

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;
    localparam logic [1:0] CMD_STOP  = 2'd3;

    localparam logic [CNT_W-1:0] CONV_LOAD    = CNT_W'(CONV_CYCLES - 1);
    localparam logic [CNT_W-1:0] BACKOFF_LOAD = CNT_W'(BACKOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    state_t           state, state_nxt;
    logic [2:0]       step, step_nxt;
    logic             pend, pend_nxt;
    logic             cmd_valid_nxt;
    logic [1:0]       cmd_nxt;
    logic             cmd_nack_nxt;
    logic [7:0]       wr_byte_nxt;
    logic [CNT_W-1:0] counter, counter_nxt;
    logic [7:0]       hi_byte, hi_nxt;
    logic [7:0]       lo_byte, lo_nxt;
    logic [7:0]       reg1_nxt, reg2_nxt;
    logic [7:0]       sample_cnt_nxt;
    logic             err_nxt;
    logic             enable_q;

    logic [1:0]       step_cmd;
    logic [7:0]       step_byte;
    logic             step_nack;
    logic             step_last;

`ifdef LIGHT_AVG_EN
    logic [17:0]      sum, sum_nxt;
    logic [1:0]       avg_phase, avg_phase_nxt;
    logic [17:0]      sum_new;

    assign sum_new = sum + {2'b00, hi_byte, lo_byte};
`endif

    assign busy = (state != ST_IDLE);

    // Command table: what the current transaction step puts on the bus.
    always_comb begin
        step_cmd  = CMD_STOP;
        step_byte = 8'h00;
        step_nack = 1'b0;
        step_last = 1'b0;
        case (state)
            ST_PWR, ST_MODE: begin
                case (step)
                    3'd0: step_cmd = CMD_START;
                    3'd1: begin
                        step_cmd  = CMD_WRITE;
                        step_byte = {DEV_ADDR, 1'b0};
                    end
                    3'd2: begin
                        step_cmd  = CMD_WRITE;
                        step_byte = (state == ST_PWR) ? PWR_CMD : MODE_CMD;
                    end
                    default: step_last = 1'b1;
                endcase
            end
            ST_READ: begin
                case (step)
                    3'd0: step_cmd = CMD_START;
                    3'd1: begin
                        step_cmd  = CMD_WRITE;
                        step_byte = {DEV_ADDR, 1'b1};
                    end
                    3'd2: step_cmd = CMD_READ;
                    3'd3: begin
                        step_cmd  = CMD_READ;
                        step_nack = 1'b1;
                    end
                    default: step_last = 1'b1;
                endcase
            end
            ST_ABORT: step_last = 1'b1;
            default: step_last = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt      = state;
        step_nxt       = step;
        pend_nxt       = pend;
        cmd_valid_nxt  = cmd_valid;
        cmd_nxt        = cmd;
        cmd_nack_nxt   = cmd_nack;
        wr_byte_nxt    = wr_byte;
        counter_nxt    = counter;
        hi_nxt         = hi_byte;
        lo_nxt         = lo_byte;
        reg1_nxt       = reg1;
        reg2_nxt       = reg2;
        sample_cnt_nxt = sample_cnt;
        err_nxt        = err;
`ifdef LIGHT_AVG_EN
        sum_nxt        = sum;
        avg_phase_nxt  = avg_phase;
`endif

        if (enable && !enable_q) begin
            err_nxt = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt = ST_PWR;
                    step_nxt  = 3'd0;
                end
            end

            ST_WAIT, ST_BACKOFF: begin
                if (!enable) begin
                    state_nxt = ST_IDLE;
                end else if (counter == '0) begin
                    state_nxt = (state == ST_WAIT) ? ST_READ : ST_PWR;
                    step_nxt  = 3'd0;
                end else begin
                    counter_nxt = counter - CNT_ONE;
                end
            end

            ST_PUB: begin
`ifdef LIGHT_AVG_EN
                if (avg_phase == 2'd3) begin
                    reg1_nxt      = sum_new[17:10];
                    reg2_nxt      = sum_new[9:2];
                    sum_nxt       = '0;
                    avg_phase_nxt = 2'd0;
                end else begin
                    sum_nxt       = sum_new;
                    avg_phase_nxt = avg_phase + 2'd1;
                end
`else
                reg1_nxt = hi_byte;
                reg2_nxt = lo_byte;
`endif
                sample_cnt_nxt = sample_cnt + 8'd1;
                state_nxt      = ST_WAIT;
                counter_nxt    = CONV_LOAD;
            end

            default: begin
                // Bus transaction states: issue, wait for accept, wait for done.
                if (pend) begin
                    if (done) begin
                        pend_nxt = 1'b0;
                        if (cmd == CMD_WRITE && ack_err) begin
                            // Slave NACK: close the bus with a STOP, then back off.
                            err_nxt   = 1'b1;
                            state_nxt = ST_ABORT;
                            step_nxt  = 3'd0;
`ifdef LIGHT_AVG_EN
                            sum_nxt       = '0;
                            avg_phase_nxt = 2'd0;
`endif
                        end else begin
                            if (cmd == CMD_READ) begin
                                if (cmd_nack) begin
                                    lo_nxt = rd_byte;
                                end else begin
                                    hi_nxt = rd_byte;
                                end
                            end
                            if (step_last) begin
                                step_nxt = 3'd0;
                                if (!enable) begin
                                    state_nxt = ST_IDLE;
                                end else begin
                                    case (state)
                                        ST_PWR:  state_nxt = ST_MODE;
                                        ST_MODE: begin
                                            state_nxt   = ST_WAIT;
                                            counter_nxt = CONV_LOAD;
                                        end
                                        ST_READ: state_nxt = ST_PUB;
                                        default: begin
                                            state_nxt   = ST_BACKOFF;
                                            counter_nxt = BACKOFF_LOAD;
                                        end
                                    endcase
                                end
                            end else begin
                                step_nxt = step + 3'd1;
                            end
                        end
                    end
                end else if (cmd_valid) begin
                    if (cmd_ready) begin
                        cmd_valid_nxt = 1'b0;
                        pend_nxt      = 1'b1;
                    end
                end else begin
                    cmd_valid_nxt = 1'b1;
                    cmd_nxt       = step_cmd;
                    wr_byte_nxt   = step_byte;
                    cmd_nack_nxt  = step_nack;
                end
            end
        endcase
    end

    always_ff @(posedge FPGA_CLK1_50) begin
        if (reset) begin
            state      <= ST_IDLE;
            step       <= 3'd0;
            pend       <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd        <= CMD_START;
            cmd_nack   <= 1'b0;
            wr_byte    <= 8'h00;
            counter    <= '0;
            hi_byte    <= 8'h00;
            lo_byte    <= 8'h00;
            reg1       <= 8'h00;
            reg2       <= 8'h00;
            sample_cnt <= 8'h00;
            err        <= 1'b0;
            enable_q   <= 1'b0;
`ifdef LIGHT_AVG_EN
            sum        <= '0;
            avg_phase  <= 2'd0;
`endif
        end else begin
            state      <= state_nxt;
            step       <= step_nxt;
            pend       <= pend_nxt;
            cmd_valid  <= cmd_valid_nxt;
            cmd        <= cmd_nxt;
            cmd_nack   <= cmd_nack_nxt;
            wr_byte    <= wr_byte_nxt;
            counter    <= counter_nxt;
            hi_byte    <= hi_nxt;
            lo_byte    <= lo_nxt;
            reg1       <= reg1_nxt;
            reg2       <= reg2_nxt;
            sample_cnt <= sample_cnt_nxt;
            err        <= err_nxt;
            enable_q   <= enable;
`ifdef LIGHT_AVG_EN
            sum        <= sum_nxt;
            avg_phase  <= avg_phase_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_light_sensor_sequencer.sv
// Bench for light_sensor_sequencer: an I2C engine model with random accept
// stalls and done delays, plus a transaction-level reference that lists the
// bus commands each phase must produce and the values that must be published.
module tb_light_sensor_sequencer;

    localparam int CONV    = 16;
    localparam int BACKOFF = 8;
    localparam int ANY     = 1000000;
    localparam logic [7:0] ADDR_W = 8'h46;
    localparam logic [7:0] ADDR_R = 8'h47;

    logic       clk = 1'b0;
    logic       reset, enable;
    logic       cmd_valid, cmd_ready, cmd_nack, done, ack_err, busy, err;
    logic [1:0] cmd;
    logic [7:0] wr_byte, rd_byte, reg1, reg2, sample_cnt;

    light_sensor_sequencer #(
        .DEV_ADDR(7'h23), .PWR_CMD(8'h01), .MODE_CMD(8'h10),
        .CONV_CYCLES(CONV), .BACKOFF_CYCLES(BACKOFF), .CNT_W(24)
    ) dut (
        .FPGA_CLK1_50(clk), .reset(reset), .enable(enable),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
        .cmd_nack(cmd_nack), .wr_byte(wr_byte), .done(done),
        .rd_byte(rd_byte), .ack_err(ack_err), .reg1(reg1), .reg2(reg2),
        .sample_cnt(sample_cnt), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    typedef struct {
        logic [1:0] c;
        logic       n;
        logic [7:0] b;
        int         gap;
    } act_t;

    typedef struct {
        logic [10:0] key;
        int          lo;
        int          hi;
    } exp_t;

    act_t act_q[$];
    exp_t exp_q[$];

    function automatic logic [10:0] key_of(input logic [1:0] c, input logic n, input logic [7:0] b);
        return {c, (c == 2'd2) ? n : 1'b0, (c == 2'd1) ? b : 8'h00};
    endfunction

    task automatic expect_cmd(input logic [1:0] c, input logic n, input logic [7:0] b,
                              input int lo, input int hi);
        exp_q.push_back(exp_t'{key_of(c, n, b), lo, hi});
    endtask

    // Whole transactions; lo/hi bound the idle gap before the START.
    task automatic exp_write_txn(input logic [7:0] opcode, input int lo, input int hi);
        expect_cmd(2'd0, 1'b0, 8'h00, lo, hi);
        expect_cmd(2'd1, 1'b0, ADDR_W, 0, ANY);
        expect_cmd(2'd1, 1'b0, opcode, 0, ANY);
        expect_cmd(2'd3, 1'b0, 8'h00, 0, ANY);
    endtask

    task automatic exp_read_txn(input int lo, input int hi);
        expect_cmd(2'd0, 1'b0, 8'h00, lo, hi);
        expect_cmd(2'd1, 1'b0, ADDR_R, 0, ANY);
        expect_cmd(2'd2, 1'b0, 8'h00, 0, ANY);
        expect_cmd(2'd2, 1'b1, 8'h00, 0, ANY);
        expect_cmd(2'd3, 1'b0, 8'h00, 0, ANY);
    endtask

    task automatic exp_nacked_txn(input logic [7:0] addr, input int lo, input int hi);
        expect_cmd(2'd0, 1'b0, 8'h00, lo, hi);
        expect_cmd(2'd1, 1'b0, addr, 0, ANY);
        expect_cmd(2'd3, 1'b0, 8'h00, 0, ANY);
    endtask

    task automatic compare_log(input string name);
        int n;
        chk($sformatf("%s_len", name), act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_cmd%0d", name, i), key_of(act_q[i].c, act_q[i].n, act_q[i].b), exp_q[i].key);
            if (exp_q[i].hi != ANY)
                chk($sformatf("%s_gap%0d_is%0d", name, i, act_q[i].gap),
                    (act_q[i].gap >= exp_q[i].lo && act_q[i].gap <= exp_q[i].hi), 1);
        end
        act_q.delete();
        exp_q.delete();
    endtask

    // Reference for published values.
    logic [7:0] exp_r1 = 8'h00, exp_r2 = 8'h00, exp_cnt = 8'h00;
    int         avg_sum = 0, avg_n = 0;

    task automatic model_publish(input logic [7:0] hi, input logic [7:0] lo);
        exp_cnt = exp_cnt + 8'd1;
`ifdef LIGHT_AVG_EN
        avg_sum += int'({hi, lo});
        avg_n++;
        if (avg_n == 4) begin
            exp_r1 = 8'((avg_sum / 4) >> 8);
            exp_r2 = 8'(avg_sum / 4);
            avg_sum = 0;
            avg_n = 0;
        end
`else
        exp_r1 = hi;
        exp_r2 = lo;
`endif
    endtask

    task automatic model_nack();
        avg_sum = 0;
        avg_n = 0;
    endtask

    task automatic check_pub(input string name);
        chk({name, "_reg1"}, reg1, exp_r1);
        chk({name, "_reg2"}, reg2, exp_r2);
        chk({name, "_cnt"}, sample_cnt, exp_cnt);
    endtask

    task automatic wait_sample(input logic [7:0] target);
        for (int i = 0; i < 3000 && sample_cnt != target; i++) @(negedge clk);
        chk("sample_wait", sample_cnt, target);
    endtask

    // I2C engine model.
    logic [7:0] rd_q[$];
    logic [7:0] nack_byte = 8'h00;
    int         nack_cnt = 0;
    int         force_stall = 0;
    int         last_done_cyc = 0;

    initial begin
        bit          pend, seen;
        int          stall_left, dly, gap;
        logic [10:0] snap;
        pend = 0; seen = 0; stall_left = 0; dly = 0; gap = 0; snap = '0;
        cmd_ready = 1'b0; done = 1'b0; rd_byte = 8'h00; ack_err = 1'b0;
        forever begin
            @(negedge clk);
            done = 1'b0;
            ack_err = 1'b0;
            if (reset) begin
                pend = 0;
                seen = 0;
                cmd_ready = 1'b0;
            end else if (pend) begin
                cmd_ready = 1'b0;
                chk("valid_while_pending", cmd_valid, 1'b0);
                dly--;
                if (dly == 0) begin
                    done = 1'b1;
                    pend = 0;
                    seen = 0;
                    last_done_cyc = cyc;
                    if (act_q.size() > 0) begin
                        if (act_q[act_q.size()-1].c == 2'd1 && nack_cnt > 0 &&
                            act_q[act_q.size()-1].b == nack_byte) begin
                            ack_err = 1'b1;
                            nack_cnt--;
                        end
                        if (act_q[act_q.size()-1].c == 2'd2)
                            rd_byte = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
                    end
                end
            end else if (cmd_valid) begin
                if (!seen) begin
                    seen = 1;
                    snap = {cmd, cmd_nack, wr_byte};
                    gap = cyc - last_done_cyc;
                    stall_left = (force_stall > 0) ? force_stall : int'($urandom_range(0, 2));
                    force_stall = 0;
                end else begin
                    chk("cmd_stable", {cmd, cmd_nack, wr_byte}, snap);
                end
                if (stall_left > 0) begin
                    cmd_ready = 1'b0;
                    stall_left--;
                end else begin
                    cmd_ready = 1'b1;
                    act_q.push_back(act_t'{cmd, cmd_nack, wr_byte, gap});
                    pend = 1;
                    dly = $urandom_range(1, 3);
                end
            end else begin
                if (seen) chk("valid_held", cmd_valid, 1'b1);
                seen = 0;
                cmd_ready = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: cycle %0d reached, limit %0d", cyc, 200000);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] h, l;
        reset = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_valid", cmd_valid, 1'b0);
        chk("rst_cmd", cmd, 2'd0);
        chk("rst_cmd_nack", cmd_nack, 1'b0);
        chk("rst_wr_byte", wr_byte, 8'h00);
        chk("rst_reg1", reg1, 8'h00);
        chk("rst_reg2", reg2, 8'h00);
        chk("rst_cnt", sample_cnt, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 1'b0);
        chk("idle_valid", cmd_valid, 1'b0);

        // First sample: power-on, mode set, conversion wait, readout.
        rd_q.push_back(8'h12); rd_q.push_back(8'h34);
        exp_write_txn(8'h01, 0, ANY);
        exp_write_txn(8'h10, 0, ANY);
        exp_read_txn(CONV, CONV + 3);
        enable = 1'b1;
        wait_sample(8'd1);
        model_publish(8'h12, 8'h34);
        check_pub("s1");
        chk("s1_busy", busy, 1'b1);
        compare_log("s1");

        rd_q.push_back(8'hAB); rd_q.push_back(8'hCD);
        exp_read_txn(CONV, CONV + 3);
        wait_sample(8'd2);
        model_publish(8'hAB, 8'hCD);
        check_pub("s2");
        compare_log("s2");

        // NACK on the read address, then on the power-on address write.
        nack_byte = ADDR_R; nack_cnt = 1;
        for (int i = 0; i < 500 && !err; i++) @(negedge clk);
        chk("nack_err", err, 1'b1);
        check_pub("nack_hold");
        model_nack();
        nack_byte = ADDR_W; nack_cnt = 1;
        exp_nacked_txn(ADDR_R, CONV, CONV + 3);
        exp_nacked_txn(ADDR_W, BACKOFF, BACKOFF + 3);
        exp_write_txn(8'h01, BACKOFF, BACKOFF + 3);
        exp_write_txn(8'h10, 0, ANY);
        exp_read_txn(CONV, CONV + 3);
        model_nack();
        rd_q.push_back(8'h55); rd_q.push_back(8'h66);
        wait_sample(8'd3);
        model_publish(8'h55, 8'h66);
        check_pub("s3");
        chk("s3_err_sticky", err, 1'b1);
        compare_log("s3");

        // Long accept stall on the next START.
        force_stall = 5;
        rd_q.push_back(8'h9A); rd_q.push_back(8'hBC);
        exp_read_txn(CONV, CONV + 3);
        wait_sample(8'd4);
        model_publish(8'h9A, 8'hBC);
        check_pub("s4");
        compare_log("s4");

        // Drop enable in the middle of a readout.
        rd_q.push_back(8'hEE); rd_q.push_back(8'hFF);
        exp_read_txn(CONV, CONV + 3);
        for (int i = 0; i < 500 && !(cmd_valid && cmd == 2'd2); i++) @(negedge clk);
        chk("drop_read_seen", (cmd_valid && cmd == 2'd2), 1'b1);
        enable = 1'b0;
        for (int i = 0; i < 500 && busy; i++) @(negedge clk);
        chk("drop_busy", busy, 1'b0);
        repeat (30) @(negedge clk);
        chk("drop_busy_later", busy, 1'b0);
        chk("drop_valid", cmd_valid, 1'b0);
        chk("drop_err_sticky", err, 1'b1);
        check_pub("drop_hold");
        compare_log("drop");

        // Re-enable clears err and restarts from power-on; random data.
        enable = 1'b1;
        repeat (2) @(negedge clk);
        chk("reen_err_clear", err, 1'b0);
        exp_write_txn(8'h01, 0, ANY);
        exp_write_txn(8'h10, 0, ANY);
        for (int s = 0; s < 5; s++) begin
            h = 8'($urandom_range(0, 255));
            l = 8'($urandom_range(0, 255));
            rd_q.push_back(h); rd_q.push_back(l);
            exp_read_txn(CONV, CONV + 3);
            wait_sample(exp_cnt + 8'd1);
            model_publish(h, l);
            check_pub($sformatf("r%0d", s));
            compare_log($sformatf("r%0d", s));
        end

        // Reset in the middle of a transaction.
        for (int i = 0; i < 500 && !cmd_valid; i++) @(negedge clk);
        chk("mid_valid_seen", cmd_valid, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", cmd_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_reg1", reg1, 8'h00);
        chk("mid_rst_reg2", reg2, 8'h00);
        chk("mid_rst_cnt", sample_cnt, 8'h00);
        enable = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
